// File: rtl/e203_exu_flush_arb_if.sv
// Flush handshake bundle between the commit stage, the flush arbiter and the IFU.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (commit-side sources plus the IFU acknowledge).
interface e203_exu_flush_arb_if #(
  parameter int PC_SIZE = 32
);
  logic               brchmis_flush_req;
  logic [PC_SIZE-1:0] brchmis_flush_add_op1;
  logic [PC_SIZE-1:0] brchmis_flush_add_op2;
  logic               brchmis_flush_ack;

  logic               excpirq_flush_req;
  logic [PC_SIZE-1:0] excpirq_flush_add_op1;
  logic [PC_SIZE-1:0] excpirq_flush_add_op2;
  logic               excpirq_flush_ack;

  logic               pipe_flush_req;
  logic [PC_SIZE-1:0] pipe_flush_pc;
  logic               pipe_flush_src;
  logic               pipe_flush_ack;

  modport slave (
    input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    output brchmis_flush_ack,
    input  excpirq_flush_req, excpirq_flush_add_op1, excpirq_flush_add_op2,
    output excpirq_flush_ack,
    output pipe_flush_req, pipe_flush_pc, pipe_flush_src,
    input  pipe_flush_ack
  );

  modport master (
    output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    input  brchmis_flush_ack,
    output excpirq_flush_req, excpirq_flush_add_op1, excpirq_flush_add_op2,
    input  excpirq_flush_ack,
    input  pipe_flush_req, pipe_flush_pc, pipe_flush_src,
    output pipe_flush_ack
  );
endinterface

// File: rtl/e203_exu_flush_arb.sv
// EXU flush arbiter: merges the branch-resolve flush and the exception/IRQ
// flush into one registered flush request toward the IFU. The exception
// source wins ties; a pending flush is held until the IFU acknowledges it,
// and a new flush may be accepted in the very cycle the IFU acknowledges.
// Optional macro E203_FLUSH_CNT_EN adds per-source flush statistic counters.
module e203_exu_flush_arb #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_exu_flush_arb_if.slave  fif,
  output logic                 flush_pend
`ifdef E203_FLUSH_CNT_EN
  ,
  output logic [CNT_W-1:0]     flush_cnt_brch,
  output logic [CNT_W-1:0]     flush_cnt_excp
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Target PC adder: plain modulo-2^PC_SIZE sum, carry discarded.
  function automatic logic [PC_SIZE-1:0] add_wrap(
    input logic [PC_SIZE-1:0] a,
    input logic [PC_SIZE-1:0] b
  );
    logic [PC_SIZE-1:0] s;
    s = a + b;
    return s;
  endfunction

  logic [0:0]         state_p1;
  logic               vld_p1;
  logic [PC_SIZE-1:0] pc_p1;
  logic               src_p1;

  logic               can_accept;
  logic               excp_win;
  logic               brch_win;
  logic               accept;
  logic [PC_SIZE-1:0] nxt_pc_p0;

  // Stage p0: arbitration and target computation (combinational, same cycle as the source request).
  // Acks are suppressed while reset is asserted so no flush is acknowledged and then lost.
  always_comb begin
    can_accept = (state_p1 == ST_IDLE) | ((state_p1 == ST_PEND) & fif.pipe_flush_ack);
    excp_win   = rst_n & can_accept & fif.excpirq_flush_req;
    brch_win   = rst_n & can_accept & fif.brchmis_flush_req & ~fif.excpirq_flush_req;
    accept     = excp_win | brch_win;
    if (fif.excpirq_flush_req) begin
      nxt_pc_p0 = add_wrap(fif.excpirq_flush_add_op1, fif.excpirq_flush_add_op2);
    end else begin
      nxt_pc_p0 = add_wrap(fif.brchmis_flush_add_op1, fif.brchmis_flush_add_op2);
    end
  end

  assign fif.excpirq_flush_ack = excp_win;
  assign fif.brchmis_flush_ack = brch_win;

  // Stage p1: flush request register held toward the IFU until acknowledged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_IDLE;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      src_p1   <= 1'b0;
    end else if (accept) begin
      state_p1 <= ST_PEND;
      vld_p1   <= 1'b1;
      pc_p1    <= nxt_pc_p0;
      src_p1   <= excp_win;
    end else if ((state_p1 == ST_PEND) && fif.pipe_flush_ack) begin
      state_p1 <= ST_IDLE;
      vld_p1   <= 1'b0;
    end
  end

  assign fif.pipe_flush_req = vld_p1;
  assign fif.pipe_flush_pc  = pc_p1;
  assign fif.pipe_flush_src = src_p1;
  assign flush_pend         = vld_p1;

`ifdef E203_FLUSH_CNT_EN
  logic [CNT_W-1:0] cnt_brch_p1;
  logic [CNT_W-1:0] cnt_excp_p1;
  logic             hsk;

  assign hsk = vld_p1 & fif.pipe_flush_ack;

  // Count completed IFU handshakes per flush source; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_brch_p1 <= '0;
      cnt_excp_p1 <= '0;
    end else if (hsk) begin
      if (src_p1) begin
        cnt_excp_p1 <= cnt_excp_p1 + 1'b1;
      end else begin
        cnt_brch_p1 <= cnt_brch_p1 + 1'b1;
      end
    end
  end

  assign flush_cnt_brch = cnt_brch_p1;
  assign flush_cnt_excp = cnt_excp_p1;
`endif

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Scoreboard bench for e203_exu_flush_arb: directed stimulus pushes the
// hand-computed flush target/source; a negedge monitor pops and compares on
// every IFU handshake. Inline checks cover acks, latency, stall and reset.
module tb_e203_exu_flush_arb;

  localparam int PC_SIZE = 32;
  localparam int CNT_W   = 32;

  typedef struct packed {
    logic [PC_SIZE-1:0] pc;
    logic               src;
  } flush_t;

  logic clk;
  logic rst_n;
  logic flush_pend;
`ifdef E203_FLUSH_CNT_EN
  logic [CNT_W-1:0] flush_cnt_brch;
  logic [CNT_W-1:0] flush_cnt_excp;
`endif

  int n_cmp;
  int n_err;
  flush_t exp_q[$];

  e203_exu_flush_arb_if #(.PC_SIZE(PC_SIZE)) fif ();

  e203_exu_flush_arb #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fif            (fif.slave),
    .flush_pend     (flush_pend)
`ifdef E203_FLUSH_CNT_EN
    ,
    .flush_cnt_brch (flush_cnt_brch),
    .flush_cnt_excp (flush_cnt_excp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fif.brchmis_flush_req     = 1'b0;
    fif.brchmis_flush_add_op1 = '0;
    fif.brchmis_flush_add_op2 = '0;
    fif.excpirq_flush_req     = 1'b0;
    fif.excpirq_flush_add_op1 = '0;
    fif.excpirq_flush_add_op2 = '0;
    fif.pipe_flush_ack        = 1'b0;
  endtask

  function automatic flush_t mk(input logic [PC_SIZE-1:0] pc, input logic src);
    flush_t f;
    f.pc  = pc;
    f.src = src;
    return f;
  endfunction

  // Monitor: every IFU handshake must match the oldest expected flush.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fif.pipe_flush_req === 1'b1 && fif.pipe_flush_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_flush", 64'(fif.pipe_flush_pc), 64'hDEAD);
      end else begin
        flush_t e;
        e = exp_q.pop_front();
        chk("sb_pc", 64'(fif.pipe_flush_pc), 64'(e.pc));
        chk("sb_src", 64'(fif.pipe_flush_src), 64'(e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();

    // 1: reset with random inputs for 2 clocks
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fif.brchmis_flush_req     = 1'($urandom);
      fif.brchmis_flush_add_op1 = $urandom;
      fif.brchmis_flush_add_op2 = $urandom;
      fif.excpirq_flush_req     = 1'($urandom);
      fif.excpirq_flush_add_op1 = $urandom;
      fif.excpirq_flush_add_op2 = $urandom;
      fif.pipe_flush_ack        = 1'($urandom);
      smp();
      chk("rst_brch_ack", 64'(fif.brchmis_flush_ack), 64'd0);
      chk("rst_excp_ack", 64'(fif.excpirq_flush_ack), 64'd0);
      chk("rst_req", 64'(fif.pipe_flush_req), 64'd0);
      chk("rst_pc", 64'(fif.pipe_flush_pc), 64'd0);
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    smp();
    chk("post_rst_pend", 64'(flush_pend), 64'd0);
    tick();

    // 2: single branch flush, IFU ack 3 cycles later
    fif.brchmis_flush_req     = 1'b1;
    fif.brchmis_flush_add_op1 = 32'h8000_0010;
    fif.brchmis_flush_add_op2 = 32'h0000_0004;
    smp();
    chk("t2_brch_ack", 64'(fif.brchmis_flush_ack), 64'd1);
    chk("t2_excp_ack", 64'(fif.excpirq_flush_ack), 64'd0);
    chk("t2_req_n", 64'(fif.pipe_flush_req), 64'd0);
    exp_q.push_back(mk(32'h8000_0014, 1'b0));
    tick();
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) fif.pipe_flush_ack = 1'b1;
      smp();
      chk("t2_req", 64'(fif.pipe_flush_req), 64'd1);
      chk("t2_pc", 64'(fif.pipe_flush_pc), 64'h8000_0014);
      chk("t2_src", 64'(fif.pipe_flush_src), 64'd0);
      tick();
    end
    idle_inputs();
    smp();
    chk("t2_req_drop", 64'(fif.pipe_flush_req), 64'd0);
    tick();

    // 3: simultaneous requests, exception first, branch back-to-back
    fif.excpirq_flush_req     = 1'b1;
    fif.excpirq_flush_add_op1 = 32'h8000_0100;
    fif.excpirq_flush_add_op2 = 32'h0000_0000;
    fif.brchmis_flush_req     = 1'b1;
    fif.brchmis_flush_add_op1 = 32'h8000_0020;
    fif.brchmis_flush_add_op2 = 32'h0000_0008;
    smp();
    chk("t3_excp_ack", 64'(fif.excpirq_flush_ack), 64'd1);
    chk("t3_brch_ack", 64'(fif.brchmis_flush_ack), 64'd0);
    exp_q.push_back(mk(32'h8000_0100, 1'b1));
    tick();
    fif.excpirq_flush_req = 1'b0;
    smp();
    chk("t3_brch_stall", 64'(fif.brchmis_flush_ack), 64'd0);
    chk("t3_pc_e", 64'(fif.pipe_flush_pc), 64'h8000_0100);
    chk("t3_src_e", 64'(fif.pipe_flush_src), 64'd1);
    tick();
    fif.pipe_flush_ack = 1'b1;
    smp();
    chk("t3_brch_ack2", 64'(fif.brchmis_flush_ack), 64'd1);
    exp_q.push_back(mk(32'h8000_0028, 1'b0));
    tick();
    idle_inputs();
    smp();
    chk("t3_nobubble_req", 64'(fif.pipe_flush_req), 64'd1);
    chk("t3_pc_b", 64'(fif.pipe_flush_pc), 64'h8000_0028);
    chk("t3_src_b", 64'(fif.pipe_flush_src), 64'd0);
    tick();
    fif.pipe_flush_ack = 1'b1;
    tick();
    fif.pipe_flush_ack = 1'b0;
    smp();
    chk("t3_req_drop", 64'(fif.pipe_flush_req), 64'd0);
    tick();

    // 5: exception arriving during a pending branch is stalled, then served in order
    fif.brchmis_flush_req     = 1'b1;
    fif.brchmis_flush_add_op1 = 32'h8000_0200;
    fif.brchmis_flush_add_op2 = 32'h0000_0040;
    smp();
    chk("t5_brch_ack", 64'(fif.brchmis_flush_ack), 64'd1);
    exp_q.push_back(mk(32'h8000_0240, 1'b0));
    tick();
    idle_inputs();
    fif.excpirq_flush_req     = 1'b1;
    fif.excpirq_flush_add_op1 = 32'h8000_0300;
    fif.excpirq_flush_add_op2 = 32'h0000_0008;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t5_stall_ack", 64'(fif.excpirq_flush_ack), 64'd0);
      chk("t5_stall_pc", 64'(fif.pipe_flush_pc), 64'h8000_0240);
      chk("t5_stall_src", 64'(fif.pipe_flush_src), 64'd0);
      tick();
    end
    fif.pipe_flush_ack = 1'b1;
    smp();
    chk("t5_excp_ack", 64'(fif.excpirq_flush_ack), 64'd1);
    exp_q.push_back(mk(32'h8000_0308, 1'b1));
    tick();
    idle_inputs();
    smp();
    chk("t5_pc_e", 64'(fif.pipe_flush_pc), 64'h8000_0308);
    chk("t5_src_e", 64'(fif.pipe_flush_src), 64'd1);
    tick();
    fif.pipe_flush_ack = 1'b1;
    tick();
    // IFU ack while idle must be ignored
    smp();
    chk("idle_ack_req", 64'(fif.pipe_flush_req), 64'd0);
    tick();
    fif.pipe_flush_ack = 1'b0;
    smp();
    chk("idle_ack_req2", 64'(fif.pipe_flush_req), 64'd0);
`ifdef E203_FLUSH_CNT_EN
    chk("cnt_brch", 64'(flush_cnt_brch), 64'd3);
    chk("cnt_excp", 64'(flush_cnt_excp), 64'd2);
`endif
    tick();

    // 4: target adder wrap
    fif.brchmis_flush_req     = 1'b1;
    fif.brchmis_flush_add_op1 = 32'hFFFF_FFFE;
    fif.brchmis_flush_add_op2 = 32'h0000_0004;
    smp();
    chk("t4_ack", 64'(fif.brchmis_flush_ack), 64'd1);
    exp_q.push_back(mk(32'h0000_0002, 1'b0));
    tick();
    idle_inputs();
    smp();
    chk("t4_pc_wrap", 64'(fif.pipe_flush_pc), 64'h0000_0002);
    tick();
    fif.pipe_flush_ack = 1'b1;
    tick();
    idle_inputs();

    // 6: reset while a flush is pending
    fif.brchmis_flush_req     = 1'b1;
    fif.brchmis_flush_add_op1 = 32'h0000_1000;
    fif.brchmis_flush_add_op2 = 32'h0000_0020;
    smp();
    exp_q.push_back(mk(32'h0000_1020, 1'b0));
    tick();
    idle_inputs();
    smp();
    chk("t6_pend", 64'(fif.pipe_flush_req), 64'd1);
    tick();
    rst_n = 1'b0;
    fif.brchmis_flush_req = 1'b1;
    fif.excpirq_flush_req = 1'b1;
    smp();
    chk("t6_rst_brch_ack", 64'(fif.brchmis_flush_ack), 64'd0);
    chk("t6_rst_excp_ack", 64'(fif.excpirq_flush_ack), 64'd0);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    exp_q.delete();
    smp();
    chk("t6_req", 64'(fif.pipe_flush_req), 64'd0);
    chk("t6_pc", 64'(fif.pipe_flush_pc), 64'd0);
    chk("t6_flush_pend", 64'(flush_pend), 64'd0);
`ifdef E203_FLUSH_CNT_EN
    chk("t6_cnt_brch", 64'(flush_cnt_brch), 64'd0);
    chk("t6_cnt_excp", 64'(flush_cnt_excp), 64'd0);
`endif
    tick();
    smp();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
